// File: rtl/script_pkg.sv
// Shared types and constants for the RemoteComm command script player.
// Opcodes sit in the top nibble of each 16-bit command word.
package script_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SNT,
    WAIT_RESP,
    FIN
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    NACK  = 2'd1,
    TMO   = 2'd2,
    EARLY = 2'd3
  } err_t;

  localparam logic [7:0] ACK_BYTE  = 8'hA5;
  localparam logic [7:0] NACK_BYTE = 8'hFF;

  localparam logic [3:0] OP_CAL  = 4'h2;
  localparam logic [3:0] OP_TOUR = 4'h7;

  function automatic logic [15:0] mk_cmd(
    input logic [3:0]  op,
    input logic [11:0] arg
  );
    return {op, arg};
  endfunction

  localparam logic [15:0] CAL_GYRO   = mk_cmd(OP_CAL, 12'h000);
  localparam logic [15:0] TOUR_START = mk_cmd(OP_TOUR, 12'h030);

endpackage

// File: rtl/script_mem.sv
// Script storage: DEPTH x 16 flop array, one write port,
// one asynchronous read port, cleared on reset.
module script_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [15:0]              wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [15:0]              rd_data
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cmd_script_player.sv
// Plays a stored command script into RemoteComm one word at a time,
// checks each response byte and reports the first failure.
module cmd_script_player
  import script_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter int         TO_W  = 26,
  parameter logic [7:0] ACK   = ACK_BYTE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [15:0]              wr_data,
  input  logic [$clog2(DEPTH):0]   num_cmds,
  input  logic                     start,
  output logic [15:0]              cmd,
  output logic                     snd_cmd,
  input  logic                     cmd_snt,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [1:0]               err_code
);

  localparam int AW = $clog2(DEPTH);
  // Leaving the wait state on this value lands the counter on all-ones.
  localparam logic [TO_W-1:0] TMO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state, state_nxt;
  logic [AW-1:0]   idx;
  logic [AW:0]     count;
  logic [TO_W-1:0] tmo;
  logic [15:0]     rd_data;
  logic            tmo_hit, last, wr_ok;
  logic            go_run, go_empty, load, adv;
  logic            ok, fail, fin, tmo_clr;
  err_t            fail_code;

  assign wr_ok   = wr_en && !busy;
  assign tmo_hit = (tmo == TMO_LAST);
  assign last    = ({1'b0, idx} == count - 1'b1);

  script_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      go_empty, fail, ok: state_nxt = FIN;
      go_run, adv:        state_nxt = SEND;
      load:               state_nxt = WAIT_SNT;
      tmo_clr:            state_nxt = WAIT_RESP;
      fin:                state_nxt = IDLE;
      default:            state_nxt = state;
    endcase
  end

  always_comb begin
    go_run    = 1'b0;
    go_empty  = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    ok        = 1'b0;
    fail      = 1'b0;
    fin       = 1'b0;
    tmo_clr   = 1'b0;
    fail_code = NONE;
    case (state)
      IDLE: begin
        if (start) begin
          go_empty = (num_cmds == '0);
          go_run   = (num_cmds != '0);
        end
      end
      SEND: load = 1'b1;
      WAIT_SNT: begin
        // A response before cmd_snt is early even if both land together.
        if (resp_rdy) begin
          fail      = 1'b1;
          fail_code = EARLY;
        end else if (tmo_hit) begin
          fail      = 1'b1;
          fail_code = TMO;
        end else if (cmd_snt) begin
          tmo_clr = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (resp_rdy) begin
          if (resp != ACK) begin
            fail      = 1'b1;
            fail_code = NACK;
          end else if (last) begin
            ok = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end else if (tmo_hit) begin
          fail      = 1'b1;
          fail_code = TMO;
        end
      end
      FIN:     fin = 1'b1;
      default: fin = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      snd_cmd  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_idx  <= '0;
      err_code <= '0;
      idx      <= '0;
      count    <= '0;
      tmo      <= '0;
    end else begin
      snd_cmd <= load;
      if (go_run || go_empty) begin
        busy     <= go_run;
        done     <= 1'b0;
        pass     <= go_empty;
        err_idx  <= '0;
        err_code <= NONE;
        count    <= num_cmds;
        idx      <= '0;
      end
      if (load) cmd <= rd_data;
      if (load || tmo_clr) tmo <= '0;
      else if (state == WAIT_SNT || state == WAIT_RESP) tmo <= tmo + 1'b1;
      if (adv) idx <= idx + 1'b1;
      if (ok) pass <= 1'b1;
      if (fail) begin
        pass     <= 1'b0;
        err_idx  <= idx;
        err_code <= fail_code;
      end
      if (fin) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_script_player.sv
// Directed bench for cmd_script_player: RemoteComm stub, transaction
// model of the expected command stream and result, per-cycle compare.
module tb_cmd_script_player;
  import script_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [4:0]  num_cmds = '0;
  logic        start = 1'b0;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        busy, done, pass;
  logic [3:0]  err_idx;
  logic [1:0]  err_code;

  cmd_script_player #(.DEPTH(16), .TO_W(8), .ACK(8'hA5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .num_cmds (num_cmds),
    .start    (start),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_idx  (err_idx),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  typedef enum int {M_OK, M_NACK, M_EARLY, M_SIMUL, M_NEVER} mode_e;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  mode_e       mode [16];
  int          snt_dly = 20;
  int          resp_dly = 100;
  int          sidx, phase, cnt, cur;
  int          trig_cyc, snd_cyc;
  bit          stub_kill = 1'b0;

  logic [15:0] sh [16];
  logic [15:0] exp_q [$];
  int          exp_pass, exp_code, exp_idx, exp_total;
  bit          run_on = 1'b0;
  bit          done_q = 1'b0;
  bit          snd_q = 1'b0;
  int          snd_cnt = 0;
  int          done_cnt = 0;

  task automatic chk(input string nm, input int act, input int want);
    nvec++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Expected outcome straight from the script and the stub's per-index plan.
  task automatic predict(input int n);
    exp_q.delete();
    exp_pass = 1;
    exp_code = 0;
    exp_idx  = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(sh[i]);
      if (mode[i] != M_OK) begin
        exp_pass = 0;
        exp_idx  = i;
        exp_code = (mode[i] == M_NACK)  ? 1 :
                   (mode[i] == M_NEVER) ? 2 : 3;
        break;
      end
    end
    exp_total = exp_q.size();
    sidx = 0;
    phase = 0;
    snd_cnt = 0;
    run_on = 1'b1;
  endtask

  // RemoteComm stub
  initial forever begin
    @(negedge clk);
    cmd_snt  = 1'b0;
    resp_rdy = 1'b0;
    resp     = 8'h00;
    if (stub_kill) begin
      phase = 0;
    end else if (phase == 0 && snd_cmd) begin
      cur = sidx;
      sidx++;
      cnt = 0;
      phase = 1;
      snd_cyc = cyc;
    end else if (phase == 1) begin
      cnt++;
      case (mode[cur])
        M_NEVER: ;
        M_EARLY: if (cnt == 3) begin
          resp_rdy = 1'b1; resp = ACK_BYTE; phase = 0; trig_cyc = cyc;
        end
        M_SIMUL: if (cnt == snt_dly) begin
          cmd_snt = 1'b1; resp_rdy = 1'b1; resp = ACK_BYTE;
          phase = 0; trig_cyc = cyc;
        end
        default: if (cnt == snt_dly) begin
          cmd_snt = 1'b1; phase = 2; cnt = 0;
        end
      endcase
    end else if (phase == 2) begin
      cnt++;
      if (cnt == resp_dly) begin
        resp_rdy = 1'b1;
        resp = (mode[cur] == M_NACK) ? NACK_BYTE : ACK_BYTE;
        phase = 0;
        trig_cyc = cyc;
      end
    end
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    if (rst_n && run_on) begin
      if (snd_cmd) begin
        chk("snd_single", int'(snd_q), 0);
        chk("snd_latency", cyc - trig_cyc, 2);
        if (exp_q.size() == 0) chk("snd_extra", snd_cnt + 1, exp_total);
        else chk("cmd_word", int'(cmd), int'(exp_q.pop_front()));
        snd_cnt++;
      end
      if (done && !done_q) begin
        chk("pass", int'(pass), exp_pass);
        chk("err_code", int'(err_code), exp_code);
        if (exp_pass == 0) chk("err_idx", int'(err_idx), exp_idx);
        chk("busy_at_done", int'(busy), 0);
        chk("snd_total", snd_cnt, exp_total);
        // Timeout: 255 counted wait cycles, then one FIN cycle.
        if (exp_code == 2) chk("tmo_latency", cyc - snd_cyc, 256);
        else chk("done_latency", cyc - trig_cyc, 2);
        done_cnt++;
      end
    end
    done_q = done;
    snd_q = snd_cmd;
  end

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a[3:0];
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    sh[a] = d;
  endtask

  task automatic start_run(input int n);
    predict(n);
    @(negedge clk);
    start = 1'b1;
    num_cmds = n[4:0];
    trig_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (n > 0) begin
      chk("busy_rise", int'(busy), 1);
      chk("snd_not_yet", int'(snd_cmd), 0);
    end
  endtask

  task automatic wait_done(input int lim);
    int tgt;
    int k;
    tgt = done_cnt + 1;
    k = 0;
    while (done_cnt < tgt && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done_cnt, tgt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmd"}, int'(cmd), 0);
    chk({tag, "_snd"}, int'(snd_cmd), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_eidx"}, int'(err_idx), 0);
    chk({tag, "_ecode"}, int'(err_code), 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16; i++) begin
      sh[i] = '0;
      mode[i] = M_OK;
    end
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;

    wr(0, CAL_GYRO);
    wr(1, TOUR_START);
    start_run(2);
    wait_done(1000);
    chk("lit_two_pass", int'(pass), 1);
    chk("lit_two_cmd", int'(cmd), 32'h7030);
    chk("lit_two_snd", snd_cnt, 2);

    snt_dly = 5;
    resp_dly = 10;
    wr(2, 16'h1234);
    mode[1] = M_NACK;
    start_run(3);
    wait_done(300);
    chk("lit_nack_code", int'(err_code), 1);
    chk("lit_nack_idx", int'(err_idx), 1);
    chk("lit_nack_snd", snd_cnt, 2);
    mode[1] = M_OK;

    snt_dly = 20;
    resp_dly = 100;
    start_run(3);
    repeat (50) @(negedge clk);
    chk("busy_mid", int'(busy), 1);
    wr_en = 1'b1;
    wr_addr = 4'd0;
    wr_data = 16'hDEAD;
    start = 1'b1;
    num_cmds = 5'd1;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    wait_done(1000);
    chk("lit_busy_pass", int'(pass), 1);
    start_run(1);
    wait_done(300);
    chk("lit_readback", int'(cmd), int'(CAL_GYRO));

    mode[0] = M_NEVER;
    start_run(2);
    wait_done(400);
    chk("lit_tmo_code", int'(err_code), 2);
    chk("lit_tmo_idx", int'(err_idx), 0);
    mode[0] = M_OK;

    snt_dly = 5;
    resp_dly = 10;
    mode[1] = M_EARLY;
    start_run(2);
    wait_done(300);
    chk("lit_early_code", int'(err_code), 3);
    chk("lit_early_idx", int'(err_idx), 1);
    mode[1] = M_OK;

    mode[0] = M_SIMUL;
    start_run(2);
    wait_done(300);
    chk("lit_simul_code", int'(err_code), 3);
    mode[0] = M_OK;

    start_run(0);
    wait_done(20);
    chk("lit_empty_pass", int'(pass), 1);
    chk("lit_empty_snd", snd_cnt, 0);

    resp_dly = 100;
    start_run(2);
    k = 0;
    while (phase != 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_wait_resp", phase, 2);
    repeat (3) @(negedge clk);
    run_on = 1'b0;
    stub_kill = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    for (int i = 0; i < 16; i++) sh[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    stub_kill = 1'b0;
    start_run(1);
    wait_done(300);
    chk("lit_mem_cleared", int'(cmd), 0);
    wr(0, CAL_GYRO);
    wr(1, TOUR_START);
    start_run(2);
    wait_done(500);
    chk("lit_replay_pass", int'(pass), 1);
    chk("lit_replay_cmd", int'(cmd), int'(TOUR_START));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
